// File: rtl/bin2bcd_seq_if.sv
// Handshake and data bundle between a requester and the sequential binary-to-BCD converter.
// The requester drives start/bin; the converter returns busy/done and the registered BCD digits.
interface bin2bcd_seq_if #(
    parameter int N_BITS   = 10,
    parameter int N_DIGITS = 4
);
    logic                  start;
    logic [N_BITS-1:0]     bin;
    logic                  busy;
    logic                  done;
    logic [4*N_DIGITS-1:0] bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, start/busy/done handshake,
// BCD output registered and only updated on completion so the displays never glitch.
module bin2bcd_seq #(
    parameter int N_BITS   = 10,
    parameter int N_DIGITS = 4
) (
    input logic          clk,
    input logic          rst_n,
    bin2bcd_seq_if.slave bus
);
    localparam int BCD_W = 4 * N_DIGITS;
    localparam int SH_W  = BCD_W + N_BITS;
    localparam int CNT_W = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [SH_W-1:0]    r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_done;
    logic [SH_W-1:0]    w_adj;
    logic [SH_W-1:0]    w_shifted;
    logic               w_last;

    always_comb begin
        w_next_state = r_state;
        w_adj        = r_shift;
        // Digit fields sit above the binary part; adjust each before the shift doubles it.
        for (int unsigned d = 0; d < N_DIGITS; d++) begin
            if (r_shift[N_BITS + 4*d +: 4] >= 4'd5) begin
                w_adj[N_BITS + 4*d +: 4] = r_shift[N_BITS + 4*d +: 4] + 4'd3;
            end
        end
        w_shifted = {w_adj[SH_W-2:0], 1'b0};
        w_last    = (r_cnt == LAST_CNT);

        case (r_state)
            IDLE:    if (bus.start) w_next_state = SHIFT;
            SHIFT:   if (w_last)    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift <= {{BCD_W{1'b0}}, bus.bin};
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_shift <= w_shifted;
                    // The counter parks at the last value instead of wrapping.
                    if (w_last) begin
                        r_bcd  <= w_shifted[SH_W-1 -: BCD_W];
                        r_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == SHIFT);
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: a cycle-level behavioural model (decimal arithmetic plus a countdown)
// is compared with the converter every cycle, with literal expectations on chosen values.
module tb_bin2bcd_seq;
    localparam int NB = 10;
    localparam int ND = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.N_BITS(NB), .N_DIGITS(ND)) bus ();

    bin2bcd_seq #(.N_BITS(NB), .N_DIGITS(ND)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic            m_busy = 1'b0;
    logic            m_done = 1'b0;
    logic [4*ND-1:0] m_bcd  = '0;
    int              m_left = 0;
    int              m_val  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Model: an accepted start makes the result appear NB edges later; start is ignored while busy.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_bcd  = '0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_bcd  = to_bcd(m_val);
                end
            end else if (bus.start) begin
                m_busy = 1'b1;
                m_left = NB;
                m_val  = int'(bus.bin);
            end
        end
        #1;
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("done", 32'(bus.done), 32'(m_done));
        check("bcd",  32'(bus.bcd),  32'(m_bcd));
    end

    task automatic do_start(input int v);
        @(negedge clk);
        bus.bin   = NB'(v);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input bit scramble, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (scramble && bus.busy) begin
                bus.bin   = NB'($urandom);
                bus.start = 1'($urandom_range(0, 1));
            end
        end
        bus.start = 1'b0;
        if (!got) begin
            n_checks++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
    endtask

    task automatic conv(input int v, input logic [15:0] exp, input string name);
        bit got;
        do_start(v);
        wait_done(1'b0, got);
        if (got) check(name, 32'(bus.bcd), 32'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   got;
        int   c0, cnt, last_done;
        logic [15:0] exp3 [3];
        bit   dig_ok;

        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(negedge clk);
        check("reset_bcd",  32'(bus.bcd),  32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;

        // Zero input and start-to-done latency
        do_start(0);
        c0 = cyc;
        wait_done(1'b0, got);
        if (got) begin
            check("latency", 32'(cyc - c0), 32'd10);
            check("bcd_0", 32'(bus.bcd), 32'h0000);
        end

        conv(1023, 16'h1023, "bcd_1023");
        conv(599,  16'h0599, "bcd_599");
        conv(1,    16'h0001, "bcd_1");

        // Start held high: back-to-back conversions every NB+1 cycles
        exp3[0] = 16'h0100;
        exp3[1] = 16'h0101;
        exp3[2] = 16'h0102;
        @(negedge clk);
        bus.bin   = NB'(100);
        bus.start = 1'b1;
        last_done = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 40; j++) begin
                @(negedge clk);
                if (bus.done) break;
            end
            check("stream_done", 32'(bus.done), 32'h1);
            check("stream_bcd", 32'(bus.bcd), 32'(exp3[i]));
            if (i > 0) check("stream_period", 32'(cyc - last_done), 32'd11);
            last_done = cyc;
            bus.bin = NB'(101 + i);
            if (i == 2) bus.start = 1'b0;
        end

        // Start and bin change mid-conversion are ignored
        do_start(345);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = NB'(5);
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = NB'(999);
        wait_done(1'b0, got);
        if (got) check("bcd_345", 32'(bus.bcd), 32'h0345);
        count_dones(15, cnt);
        check("no_extra_done", 32'(cnt), 32'h0);

        // Reset mid-conversion discards the partial result and the previous value
        conv(12, 16'h0012, "bcd_12");
        do_start(777);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_bcd",  32'(bus.bcd),  32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        count_dones(15, cnt);
        check("midrst_no_done", 32'(cnt), 32'h0);
        conv(777, 16'h0777, "bcd_777");

        // Full sweep with random noise on bin/start while busy
        for (int v = 0; v < (1 << NB); v++) begin
            do_start(v);
            wait_done(1'b1, got);
            if (got) begin
                dig_ok = 1'b1;
                for (int k = 0; k < ND; k++) begin
                    if (bus.bcd[4*k +: 4] > 4'd9) dig_ok = 1'b0;
                end
                check("sweep_digits", 32'(dig_ok), 32'h1);
                check("sweep_bcd", 32'(bus.bcd), 32'(to_bcd(v)));
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
